// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
//   arb_state_e : arbiter service state
//   BLOCK_WORDS / WORD_IDX_W / BLOCK_OFF_LSB : cache block geometry
//   word_addr() : byte address of one word within a block
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFILL  = 2'd1,
    DFILL  = 2'd2,
    DWRITE = 2'd3
  } arb_state_e;

  localparam int BLOCK_WORDS   = 8;
  localparam int WORD_IDX_W    = 3;
  localparam int BLOCK_OFF_LSB = 1;
  // Lowest bit of the block tag (address bits above the in-block offset).
  localparam int TAG_LSB       = BLOCK_OFF_LSB + WORD_IDX_W;

  // Word addresses never carry out of the index field, so a fill can
  // never leave its 16-byte block.
  function automatic logic [15:0] word_addr(input logic [15:TAG_LSB]      tag,
                                            input logic [WORD_IDX_W-1:0] idx);
    return {tag, idx, {BLOCK_OFF_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_sequencer.sv
// fill_sequencer: issue/receive counters for one block fill.
//   start     : grant of a fill in IDLE; latches tag_in, clears counters
//   tag_in    : block tag of the requester being granted
//   active    : a fill is in service
//   mem_valid : returned word this cycle
//   iss_en    : issue a read this cycle, iss_addr is its byte address
//   rcv_idx   : index of the word currently returning
//   rcv_we    : returned word is accepted
//   last      : accepted word is the final word of the block
module fill_sequencer
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:TAG_LSB]     tag_in,
  input  logic                  active,
  input  logic                  mem_valid,
  output logic                  iss_en,
  output logic [15:0]           iss_addr,
  output logic [WORD_IDX_W-1:0] rcv_idx,
  output logic                  rcv_we,
  output logic                  last
);

  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(BLOCK_WORDS - 1);

  logic [15:TAG_LSB]     tag_q, tag_d;
  logic [WORD_IDX_W-1:0] iss_q, iss_d;
  logic [WORD_IDX_W-1:0] rcv_q, rcv_d;
  // Set once all words have been issued; the issue counter itself wraps.
  logic                  iss_wrap_q, iss_wrap_d;

  assign iss_en   = active && !iss_wrap_q;
  assign iss_addr = iss_en ? word_addr(tag_q, iss_q) : 16'h0000;
  assign rcv_we   = active && mem_valid;
  assign rcv_idx  = rcv_q;
  assign last     = rcv_we && (rcv_q == LAST_IDX);

  always_comb begin
    tag_d      = tag_q;
    iss_d      = iss_q;
    rcv_d      = rcv_q;
    iss_wrap_d = iss_wrap_q;
    if (start) begin
      tag_d      = tag_in;
      iss_d      = '0;
      rcv_d      = '0;
      iss_wrap_d = 1'b0;
    end else if (active) begin
      if (iss_en) begin
        iss_d = iss_q + WORD_IDX_W'(1);
        if (iss_q == LAST_IDX) iss_wrap_d = 1'b1;
      end
      if (rcv_we) rcv_d = rcv_q + WORD_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      iss_q      <= '0;
      rcv_q      <= '0;
      iss_wrap_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
      iss_wrap_q <= iss_wrap_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory between I-cache fills,
// D-cache fills and D-cache write-through stores.
//   i_req/i_addr                 : I-cache block fill request
//   d_req/d_wr/d_addr/d_wdata    : D-cache fill or store request
//   mem_*                        : memory command / read return
//   fill_data/fill_word/*_fill_we: returned words routed to the granted cache
//   i_done/d_done/d_wr_ack       : completion pulses
//   i_grant/d_grant              : high while that side is in service
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_done,
  output logic        d_done,
  output logic        d_wr_ack,
  output logic        i_grant,
  output logic        d_grant
);

  // The sequencer counts returns rather than cycles, so latency only has
  // to be positive; block geometry is fixed by the package.
  if (BLOCK_WORDS != mem_arb_pkg::BLOCK_WORDS || MEM_LAT < 1) begin : g_bad_cfg
    $error("mem_arbiter: unsupported BLOCK_WORDS/MEM_LAT");
  end

  arb_state_e state_q, state_d;

  logic                  fill_start;
  logic [15:TAG_LSB]     fill_tag;
  logic                  in_fill;
  logic                  seq_iss_en;
  logic [15:0]           seq_iss_addr;
  logic [WORD_IDX_W-1:0] seq_rcv_idx;
  logic                  seq_rcv_we;
  logic                  seq_last;

  // Offset bits of the I-side address are irrelevant to a block fill.
  logic unused_i_off;
  assign unused_i_off = ^i_addr[TAG_LSB-1:0];

  // D side wins in IDLE; a pending store defers an I fill but not a D fill.
  assign fill_start = (state_q == IDLE) && (d_req || (!d_wr && i_req));
  assign fill_tag   = d_req ? d_addr[15:TAG_LSB] : i_addr[15:TAG_LSB];
  assign in_fill    = (state_q == IFILL) || (state_q == DFILL);

  fill_sequencer u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (fill_start),
    .tag_in    (fill_tag),
    .active    (in_fill),
    .mem_valid (mem_valid),
    .iss_en    (seq_iss_en),
    .iss_addr  (seq_iss_addr),
    .rcv_idx   (seq_rcv_idx),
    .rcv_we    (seq_rcv_we),
    .last      (seq_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req)      state_d = DFILL;
        else if (d_wr)  state_d = DWRITE;
        else if (i_req) state_d = IFILL;
      end
      IFILL, DFILL: if (seq_last) state_d = IDLE;
      DWRITE:       state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    mem_en    = seq_iss_en;
    mem_wr    = 1'b0;
    mem_addr  = seq_iss_addr;
    mem_wdata = 16'h0000;
    fill_data = in_fill ? mem_rdata : 16'h0000;
    fill_word = in_fill ? seq_rcv_idx : '0;
    i_fill_we = (state_q == IFILL) && seq_rcv_we;
    d_fill_we = (state_q == DFILL) && seq_rcv_we;
    i_done    = (state_q == IFILL) && seq_last;
    d_done    = (state_q == DFILL) && seq_last;
    d_wr_ack  = 1'b0;
    i_grant   = (state_q == IFILL);
    d_grant   = (state_q == DFILL) || (state_q == DWRITE);
    if (state_q == DWRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      d_wr_ack  = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, i_grant, d_grant;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack),
    .i_grant(i_grant), .d_grant(d_grant)
  );

  // Memory model: fixed-latency read pipeline, never reset (stale returns).
  logic [15:0]        rd_base = 16'h0000;
  logic [MEM_LAT-1:0] pv = '0;
  logic [15:0]        pa [MEM_LAT] = '{default: 16'h0000};

  always @(posedge clk) begin
    pv    <= {pv[MEM_LAT-2:0], mem_en && !mem_wr};
    pa[0] <= mem_addr;
    for (int k = 1; k < MEM_LAT; k++) pa[k] <= pa[k-1];
  end
  assign mem_valid = pv[MEM_LAT-1];
  assign mem_rdata = mem_valid ? rd_base + 16'(pa[MEM_LAT-1][3:1]) : 16'h0000;

  // Scoreboard
  typedef struct packed {
    logic        is_d;
    logic [2:0]  word;
    logic [15:0] data;
  } fill_t;

  fill_t       exp_fill[$];
  logic [15:0] exp_rd[$];
  logic [31:0] exp_wr[$];

  task automatic push_fill(input logic is_d, input logic [15:0] addr,
                           input int n_addr, input int n_data);
    for (int n = 0; n < n_addr; n++) exp_rd.push_back({addr[15:4], 3'(n), 1'b0});
    for (int n = 0; n < n_data; n++) exp_fill.push_back({is_d, 3'(n), rd_base + 16'(n)});
  endtask

  always @(negedge clk) begin : monitor
    fill_t       e;
    logic [15:0] ea;
    logic [31:0] ew;
    if (i_fill_we || d_fill_we) begin
      n_cmp++;
      if (exp_fill.size() == 0) begin
        n_fail++;
        $display("FAIL fill_unexpected: got word %0d data %h, none expected", fill_word, fill_data);
      end else begin
        e = exp_fill.pop_front();
        if ({d_fill_we, i_fill_we, fill_word, fill_data} !== {e.is_d, !e.is_d, e.word, e.data}) begin
          n_fail++;
          $display("FAIL fill_word: got d=%0b i=%0b w=%0d %h, want d=%0b w=%0d %h",
                   d_fill_we, i_fill_we, fill_word, fill_data, e.is_d, e.word, e.data);
        end
      end
    end
    if (mem_en && !mem_wr) begin
      n_cmp++;
      if (exp_rd.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got addr %h, none expected", mem_addr);
      end else begin
        ea = exp_rd.pop_front();
        if (mem_addr !== ea) begin
          n_fail++;
          $display("FAIL rd_addr: got %h want %h", mem_addr, ea);
        end
      end
    end
    if (mem_en && mem_wr) begin
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got %h/%h, none expected", mem_addr, mem_wdata);
      end else begin
        ew = exp_wr.pop_front();
        if ({mem_addr, mem_wdata} !== ew) begin
          n_fail++;
          $display("FAIL wr_cmd: got %h/%h want %h/%h", mem_addr, mem_wdata, ew[31:16], ew[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) tick();
    n_cmp++;
    if ({mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, i_grant, d_grant} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0",
        {mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, i_grant, d_grant});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, fill_data} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h want 0", mem_addr, mem_wdata, fill_data);
    end
    n_cmp++;
    if (fill_word !== 3'd0) begin
      n_fail++; $display("FAIL reset_fill_word: got %0d want 0", fill_word);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_imiss();
    int dk = -1;
    rd_base = 16'hA000;
    push_fill(1'b0, 16'h1236, 8, 8);
    i_req = 1; i_addr = 16'h1236;
    for (int k = 1; k <= 20 && dk < 0; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++;
        if ({i_grant, d_grant} !== 2'b10) begin
          n_fail++; $display("FAIL imiss_grant: got i=%0b d=%0b want i=1 d=0", i_grant, d_grant);
        end
      end
      if (k == 2) i_addr = 16'hFFFE;  // must be ignored after grant
      if (i_done) begin dk = k; i_req = 0; end
    end
    n_cmp++;
    if (dk != 12) begin n_fail++; $display("FAIL imiss_done_cycle: got %0d want 12", dk); end
    tick();
    n_cmp++;
    if ({i_done, i_grant, mem_en} !== 3'b000) begin
      n_fail++; $display("FAIL imiss_idle: got done/grant/en %b want 000", {i_done, i_grant, mem_en});
    end
  endtask

  task automatic test_priority();
    int dk = -1, ig = -1, ik = -1;
    rd_base = 16'hB000;
    push_fill(1'b1, 16'h4008, 8, 8);
    push_fill(1'b0, 16'h2220, 8, 8);
    i_req = 1; i_addr = 16'h2220; d_req = 1; d_addr = 16'h4008;
    for (int k = 1; k <= 40 && ik < 0; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++;
        if ({d_grant, i_grant} !== 2'b10) begin
          n_fail++; $display("FAIL prio_grant: got d=%0b i=%0b want d=1 i=0", d_grant, i_grant);
        end
      end
      if (d_done && dk < 0) begin dk = k; d_req = 0; end
      if (i_grant && ig < 0) ig = k;
      if (i_done) begin ik = k; i_req = 0; end
    end
    n_cmp++;
    if (dk != 12) begin n_fail++; $display("FAIL prio_d_done: got %0d want 12", dk); end
    n_cmp++;
    if (ig != 14) begin n_fail++; $display("FAIL prio_i_grant: got %0d want 14", ig); end
    n_cmp++;
    if (ik != 25) begin n_fail++; $display("FAIL prio_i_done: got %0d want 25", ik); end
    tick();
  endtask

  task automatic test_dwrite();
    exp_wr.push_back({16'h0100, 16'hBEEF});
    d_wr = 1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    tick();
    n_cmp++;
    if ({mem_en, mem_wr, d_wr_ack, d_grant, i_grant} !== 5'b11110) begin
      n_fail++; $display("FAIL dwrite_cycle1: got en/wr/ack/dg/ig %b want 11110",
                         {mem_en, mem_wr, d_wr_ack, d_grant, i_grant});
    end
    d_wr = 0;
    tick();
    n_cmp++;
    if ({mem_en, d_wr_ack, d_grant} !== 3'b000) begin
      n_fail++; $display("FAIL dwrite_cycle2: got en/ack/grant %b want 000", {mem_en, d_wr_ack, d_grant});
    end
  endtask

  task automatic test_drop_req();
    int dk = -1;
    rd_base = 16'hC000;
    push_fill(1'b0, 16'h3456, 8, 8);
    i_req = 1; i_addr = 16'h3456;
    for (int k = 1; k <= 20 && dk < 0; k++) begin
      tick();
      if (k == 3) i_req = 0;
      if (i_done) dk = k;
    end
    n_cmp++;
    if (dk != 12) begin n_fail++; $display("FAIL drop_done_cycle: got %0d want 12", dk); end
    tick();
  endtask

  task automatic test_reset_midfill();
    int we_seen = 0, done_seen = 0, stale = 0;
    rd_base = 16'hD000;
    push_fill(1'b1, 16'h5000, 6, 2);
    d_req = 1; d_addr = 16'h5000;
    repeat (6) tick();
    rst = 1; d_req = 0;
    #1;
    n_cmp++;
    if ({mem_en, d_grant, d_fill_we, mem_addr, fill_word} !== 22'h0) begin
      n_fail++; $display("FAIL rst_async: got en=%0b g=%0b we=%0b addr=%h w=%0d want 0",
                         mem_en, d_grant, d_fill_we, mem_addr, fill_word);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 1) rst = 0;
      if (d_fill_we) we_seen++;
      if (d_done) done_seen++;
      if (mem_valid) stale++;
    end
    n_cmp++;
    if (we_seen != 0 || done_seen != 0) begin
      n_fail++; $display("FAIL rst_stale: got we=%0d done=%0d (stale=%0d) want 0", we_seen, done_seen, stale);
    end
  endtask

  task automatic test_fill_then_write();
    int dk = -1, wk = -1;
    rd_base = 16'hE000;
    push_fill(1'b1, 16'h6002, 8, 8);
    exp_wr.push_back({16'h6002, 16'h1234});
    d_req = 1; d_wr = 1; d_addr = 16'h6002; d_wdata = 16'h1234;
    for (int k = 1; k <= 30 && wk < 0; k++) begin
      tick();
      if (k == 13) begin
        n_cmp++;
        if ({d_grant, d_wr_ack} !== 2'b00) begin
          n_fail++; $display("FAIL fw_idle_gap: got grant/ack %b want 00", {d_grant, d_wr_ack});
        end
      end
      if (d_done && dk < 0) begin dk = k; d_req = 0; end
      if (d_wr_ack) begin wk = k; d_wr = 0; end
    end
    n_cmp++;
    if (dk != 12) begin n_fail++; $display("FAIL fw_done: got %0d want 12", dk); end
    n_cmp++;
    if (wk != 14) begin n_fail++; $display("FAIL fw_ack: got %0d want 14", wk); end
    tick();
  endtask

  initial begin
    test_reset();
    test_imiss();
    test_priority();
    test_dwrite();
    test_drop_req();
    test_reset_midfill();
    test_fill_then_write();
    repeat (2) tick();
    n_cmp++;
    if (exp_fill.size() != 0 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_fail++; $display("FAIL queues_drained: got fill=%0d rd=%0d wr=%0d left want 0",
                         exp_fill.size(), exp_rd.size(), exp_wr.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single shared, pipelined main memory between the I-cache and D-cache miss handlers of the 5-stage CPU. It sequences 8-word block fills, streaming returned words to the granted cache with a word index, and issues single-word write-through stores from the D-cache. It sits between both cache controllers and the memory model, so all cache hit/miss traffic reaches memory only through this block.

## Interface
Parameters:
- MEM_LAT, 4: cycles from address issue to matching `mem_valid` data
- BLOCK_WORDS, 8: 16-bit words per cache block (16 bytes)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  I-cache miss fill request, level, held until `i_done`
- i_addr  in  16  I-cache miss byte address
- d_req  in  1  D-cache fill request, level, held until `d_done`
- d_wr  in  1  D-cache write request, level, held until `d_wr_ack`
- d_addr  in  16  D-cache byte address (fill or write)
- d_wdata  in  16  D-cache store data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  `mem_rdata` valid this cycle
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  access is a write (qualified by `mem_en`)
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- fill_data  out  16  returned word, equals `mem_rdata`
- fill_word  out  3  word index of `fill_data` within block
- i_fill_we, d_fill_we  out  1  write `fill_data` into I/D data array
- i_done, d_done  out  1  one-cycle pulse with last fill word
- d_wr_ack  out  1  one-cycle pulse, store issued
- i_grant, d_grant  out  1  high throughout service of that requester

## Operation
- FSM states: IDLE, IFILL, DFILL, DWRITE; registered, reset to IDLE.
- IDLE priority, sampled at the rising edge: `d_req` → DFILL; else `d_wr` → DWRITE; else `i_req` → IFILL. The D side has fixed priority because it stalls an older instruction. No preemption once granted.
- Fill (IFILL/DFILL):
  - The issue counter iss (0..7) drives `mem_en`=1, `mem_wr`=0, `mem_addr`={addr[15:4], iss, 1'b0} for 8 consecutive cycles, word 0 first. `mem_en`=0 once iss has wrapped.
  - The receive counter rcv (0..7) increments on each `mem_valid`. `fill_word`=rcv; `*_fill_we`=`mem_valid` for the granted side.
  - `*_done` is asserted with the `mem_valid` of rcv=7; the next state is IDLE.
  - The block address is latched at grant; later changes to `*_addr` are ignored.
- DWRITE: one cycle. `mem_en`=1, `mem_wr`=1, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`, `d_wr_ack`=1. Next state is IDLE.
- `mem_valid` is ignored in IDLE and DWRITE.
- Requester deasserting mid-fill: the fill still completes and `*_done` still pulses.
- Both `d_req` and `d_wr` high in IDLE: the fill is taken first, and the write is served on a later IDLE.
- Address arithmetic is 16-bit with no carry out of bits [3:1]. The block never crosses a 16-byte boundary.

## Timing
- Reset: every output is 0 (`mem_addr`, `mem_wdata`, `fill_word` = 0). State is IDLE and counters are 0.
- Reset mid-fill aborts immediately. Stale `mem_valid` returns after reset are ignored, and no `*_done` is issued.
- Request sampled at edge E0: addresses are issued in cycles 1–8, data returns in cycles 1+MEM_LAT to 8+MEM_LAT, and `done` pulses in cycle 8+MEM_LAT (cycle 12 for the defaults).
- IDLE is occupied for at least one cycle between services. A new request is sampled at the edge ending the done cycle +1, so back-to-back fills are separated by one idle cycle.
- Write: sampled at E0, issued and acknowledged in cycle 1, IDLE in cycle 2.
- `mem_en` never overlaps a write with outstanding reads. Fills return to IDLE only after all 8 words have been received.

## Structure
- `mem_arb_pkg`: state enum (IDLE/IFILL/DFILL/DWRITE), `BLOCK_WORDS`=8, `WORD_IDX_W`=3, `BLOCK_OFF_LSB`=1.
- Sub-module `fill_sequencer` contains the iss/rcv counters, address formation and the last-word detect. It is instantiated once, with the grant selecting the source.

## Test plan
- Single I-miss: `i_req`, `i_addr`=0x1236. `mem_addr` steps 0x1230, 0x1232 … 0x123E in cycles 1–8. The memory returns 0xA000+n, so `i_fill_we` is high with `fill_word` 0..7 in cycles 5–12 and `i_done` pulses in cycle 12.
- Simultaneous `i_req` and `d_req` (`d_addr`=0x4008): DFILL is served first (addresses 0x4000–0x400E). `i_grant` rises after `d_done` plus one idle cycle.
- D write: `d_wr`, `d_addr`=0x0100, `d_wdata`=0xBEEF. In cycle 1, `mem_en`=`mem_wr`=1, `mem_addr`=0x0100, `mem_wdata`=0xBEEF and `d_wr_ack`=1.
- `i_req` is dropped in cycle 3 of a fill: all 8 words are still written and `i_done` still pulses.
- `rst` is asserted in cycle 6 of a DFILL: outputs go to 0 asynchronously, the remaining `mem_valid` pulses cause no `d_fill_we`, and no `d_done` is issued.
- `d_req` and `d_wr` are both held: the fill completes, then the write is acknowledged two cycles after `d_done`.
